// File: rtl/roam_pkg.sv
// Shared key codes, facing directions, controller states and a small
// arithmetic helper for the overworld roam controller.
package roam_pkg;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    ROAM   = 1'b0,
    BATTLE = 1'b1
  } roam_state_t;

  // Unsigned distance between two widened coordinates; never wraps.
  function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/roam_npc_check.sv
// Per-NPC geometry: does the trainer's candidate box overlap this NPC, and
// is the trainer standing close to and facing this NPC.
module roam_npc_check
  import roam_pkg::*;
#(
  parameter int SPR_W  = 14,
  parameter int SPR_H  = 16,
  parameter int TALK_R = 3
) (
  input  logic        active,
  input  logic [9:0]  npc_x,
  input  logic [9:0]  npc_y,
  input  logic [11:0] cand_x,
  input  logic [11:0] cand_y,
  input  logic [9:0]  tx,
  input  logic [9:0]  ty,
  input  dir_t        dir,
  output logic        block,
  output logic        hit
);

  localparam logic [11:0] SW = 12'(SPR_W);
  localparam logic [11:0] SH = 12'(SPR_H);
  localparam logic [11:0] R  = 12'(TALK_R);

  logic [11:0] nx, ny, txe, tye, dx, dy;
  logic        face;

  assign nx  = {2'b00, npc_x};
  assign ny  = {2'b00, npc_y};
  assign txe = {2'b00, tx};
  assign tye = {2'b00, ty};
  assign dx  = abs_diff(txe, nx);
  assign dy  = abs_diff(tye, ny);

  // Axis-aligned box overlap between the candidate trainer box and this NPC.
  always_comb begin
    block = active
            && (cand_x < nx + SW) && (nx < cand_x + SW)
            && (cand_y < ny + SH) && (ny < cand_y + SH);
  end

  // Facing test: trainer adjacent to the NPC edge it is looking at, within tolerance.
  always_comb begin
    face = 1'b0;
    case (dir)
      UP:      face = (dx <= R) && (tye >= ny + SH) && (tye <= ny + SH + R);
      DOWN:    face = (dx <= R) && (tye + SH + R >= ny) && (tye + SH <= ny);
      LEFT:    face = (dy <= R) && (txe >= nx + SW) && (txe <= nx + SW + R);
      RIGHT:   face = (dy <= R) && (txe + SW + R >= nx) && (txe + SW <= nx);
      default: face = 1'b0;
    endcase
    hit = active && face;
  end

endmodule

// File: rtl/roam_ctrl.sv
// Overworld roam controller: trainer movement and facing, ENTER-triggered
// battle arbitration over N_NPC trainers, defeat tracking and exit door gating.
module roam_ctrl
  import roam_pkg::*;
#(
  parameter int N_NPC      = 5,
  parameter int MAP_X      = 300,
  parameter int MAP_Y      = 100,
  parameter int MAP_W      = 192,
  parameter int MAP_H      = 255,
  parameter int TOP_MARGIN = 25,
  parameter int SPR_W      = 14,
  parameter int SPR_H      = 16,
  parameter int STEP       = 1,
  parameter int MOVE_DIV   = 1,
  parameter int TALK_R     = 3,
  parameter int START_X    = 387,
  parameter int START_Y    = 336,
  parameter int EXIT_X     = 389,
  parameter int EXIT_TOL   = 3,
  localparam int IDX_W     = (N_NPC > 1) ? $clog2(N_NPC) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic                   is_roam,
  input  logic                   is_start,
  input  logic [7:0]             keycode,
  input  logic [N_NPC-1:0][9:0]  npc_x,
  input  logic [N_NPC-1:0][9:0]  npc_y,
  input  logic [N_NPC-1:0]       npc_active,
  input  logic                   battle_done,
  output logic [9:0]             trainer_x,
  output logic [9:0]             trainer_y,
  output logic [1:0]             trainer_dir,
  output logic [1:0]             walk_frame,
  output logic                   start_battle,
  output logic [IDX_W-1:0]       battle_idx,
  output logic                   new_room,
  output logic [N_NPC-1:0]       defeated
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [11:0] X_MIN = 12'(MAP_X);
  localparam logic [11:0] X_MAX = 12'(MAP_X + MAP_W - SPR_W);
  localparam logic [11:0] Y_MIN = 12'(MAP_Y + TOP_MARGIN);
  localparam logic [11:0] Y_MAX = 12'(MAP_Y + MAP_H - SPR_H);
  localparam logic [11:0] STP   = 12'(STEP);

  roam_state_t      state, state_n;
  dir_t             dir_q, dir_n, key_dir;
  logic [2:0]       frame_sync;
  logic             enter_q;
  logic [CNT_W-1:0] move_cnt, cnt_n;
  logic [9:0]       tx_n, ty_n;
  logic [1:0]       wf_n;
  logic [N_NPC-1:0] def_n;
  logic [IDX_W-1:0] bidx_n, hit_idx;
  logic             sb_n, nr_n;

  logic             tick, key_dir_vld, enter_edge, enter_hit, exit_ok;
  logic             bound_ok, step_ok;
  logic [11:0]      txe, tye, cand_x, cand_y;
  logic [N_NPC-1:0] block_vec, face_vec, hit_vec;

  assign trainer_dir = dir_q;
  assign txe         = {2'b00, trainer_x};
  assign tye         = {2'b00, trainer_y};
  assign tick        = frame_sync[1] & ~frame_sync[2];
  assign enter_edge  = (keycode == KEY_ENTER) && !enter_q;
  assign hit_vec     = face_vec & ~defeated;
  assign enter_hit   = (state == ROAM) && is_roam && enter_edge && (|hit_vec);
  assign step_ok     = bound_ok && !(|block_vec);
  assign exit_ok     = ((defeated & npc_active) == npc_active)
                       && (tye <= Y_MIN)
                       && (abs_diff(txe, 12'(EXIT_X)) <= 12'(EXIT_TOL));

  // Frame tick synchroniser/edge detector and ENTER level history.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_sync <= '0;
      enter_q    <= 1'b0;
    end else begin
      frame_sync <= {frame_sync[1:0], frame_clk};
      enter_q    <= (keycode == KEY_ENTER);
    end
  end

  // Decode movement keys into a direction.
  always_comb begin
    key_dir_vld = 1'b1;
    key_dir     = UP;
    case (keycode)
      KEY_W:   key_dir = UP;
      KEY_S:   key_dir = DOWN;
      KEY_A:   key_dir = LEFT;
      KEY_D:   key_dir = RIGHT;
      default: key_dir_vld = 1'b0;
    endcase
  end

  // Candidate position one step along the facing; bounds compared before subtracting.
  always_comb begin
    cand_x   = txe;
    cand_y   = tye;
    bound_ok = 1'b0;
    case (dir_q)
      UP:      begin bound_ok = (tye >= Y_MIN + STP); cand_y = tye - STP; end
      DOWN:    begin bound_ok = (tye + STP <= Y_MAX); cand_y = tye + STP; end
      LEFT:    begin bound_ok = (txe >= X_MIN + STP); cand_x = txe - STP; end
      RIGHT:   begin bound_ok = (txe + STP <= X_MAX); cand_x = txe + STP; end
      default: bound_ok = 1'b0;
    endcase
  end

  for (genvar g = 0; g < N_NPC; g++) begin : g_npc
    roam_npc_check #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H),
      .TALK_R(TALK_R)
    ) u_chk (
      .active(npc_active[g]),
      .npc_x (npc_x[g]),
      .npc_y (npc_y[g]),
      .cand_x(cand_x),
      .cand_y(cand_y),
      .tx    (trainer_x),
      .ty    (trainer_y),
      .dir   (dir_q),
      .block (block_vec[g]),
      .hit   (face_vec[g])
    );
  end

  // Lowest-index undefeated NPC in facing range wins the interaction.
  always_comb begin
    hit_idx = '0;
    for (int i = N_NPC - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

  // Next-state and next-output logic for the ROAM/BATTLE controller.
  always_comb begin
    state_n = state;
    tx_n    = trainer_x;
    ty_n    = trainer_y;
    dir_n   = dir_q;
    wf_n    = walk_frame;
    cnt_n   = move_cnt;
    def_n   = defeated;
    bidx_n  = battle_idx;
    sb_n    = 1'b0;
    nr_n    = 1'b0;
    case (state)
      BATTLE: begin
        if (battle_done) begin
          def_n[battle_idx] = 1'b1;
          state_n           = ROAM;
        end
      end
      ROAM: begin
        if (enter_hit) begin
          bidx_n  = hit_idx;
          sb_n    = 1'b1;
          state_n = BATTLE;
        end else if (tick && is_roam) begin
          if (exit_ok) begin
            nr_n  = 1'b1;
            tx_n  = 10'(START_X);
            ty_n  = 10'(START_Y);
            dir_n = UP;
            def_n = '0;
          end else if (!key_dir_vld) begin
            wf_n = 2'd0;
          end else if (key_dir != dir_q) begin
            dir_n = key_dir;
            cnt_n = '0;
          end else if (move_cnt == CNT_W'(MOVE_DIV - 1)) begin
            cnt_n = '0;
            if (step_ok) begin
              tx_n = cand_x[9:0];
              ty_n = cand_y[9:0];
              wf_n = walk_frame + 2'd1;
            end
          end else begin
            cnt_n = move_cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = ROAM;
    endcase
  end

  // State and output registers; title screen behaves as a soft reset.
  always_ff @(posedge Clk) begin
    if (Reset || is_start) begin
      state        <= ROAM;
      trainer_x    <= 10'(START_X);
      trainer_y    <= 10'(START_Y);
      dir_q        <= UP;
      walk_frame   <= 2'd0;
      move_cnt     <= '0;
      defeated     <= '0;
      battle_idx   <= '0;
      start_battle <= 1'b0;
      new_room     <= 1'b0;
    end else begin
      state        <= state_n;
      trainer_x    <= tx_n;
      trainer_y    <= ty_n;
      dir_q        <= dir_n;
      walk_frame   <= wf_n;
      move_cnt     <= cnt_n;
      defeated     <= def_n;
      battle_idx   <= bidx_n;
      start_battle <= sb_n;
      new_room     <= nr_n;
    end
  end

endmodule

// File: tb/tb_roam_ctrl.sv
// Directed bench for roam_ctrl: movement table plus battle, exit and soft-reset sequences.
module tb_roam_ctrl;

  localparam int N = 5;

  logic             Clk = 1'b0;
  logic             Reset, frame_clk, is_roam, is_start, battle_done;
  logic [7:0]       keycode;
  logic [N-1:0][9:0] npc_x, npc_y;
  logic [N-1:0]     npc_active;

  logic [9:0] trainer_x, trainer_y;
  logic [1:0] trainer_dir, walk_frame;
  logic       start_battle, new_room;
  logic [2:0] battle_idx;
  logic [N-1:0] defeated;

  logic [9:0] t3_x, t3_y;
  logic [1:0] t3_dir, t3_wf;
  logic       t3_sb, t3_nr;
  logic [2:0] t3_idx;
  logic [N-1:0] t3_def;

  int n_tests = 0;
  int n_fail  = 0;
  int sb_cnt  = 0;
  int nr_cnt  = 0;
  logic [9:0] nr_x, nr_y;
  logic [N-1:0] nr_def;

  always #5 Clk = ~Clk;

  roam_ctrl #(.N_NPC(N), .MOVE_DIV(1)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .is_roam(is_roam),
    .is_start(is_start), .keycode(keycode), .npc_x(npc_x), .npc_y(npc_y),
    .npc_active(npc_active), .battle_done(battle_done),
    .trainer_x(trainer_x), .trainer_y(trainer_y), .trainer_dir(trainer_dir),
    .walk_frame(walk_frame), .start_battle(start_battle), .battle_idx(battle_idx),
    .new_room(new_room), .defeated(defeated)
  );

  roam_ctrl #(.N_NPC(N), .MOVE_DIV(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .is_roam(is_roam),
    .is_start(is_start), .keycode(keycode), .npc_x(npc_x), .npc_y(npc_y),
    .npc_active(npc_active), .battle_done(battle_done),
    .trainer_x(t3_x), .trainer_y(t3_y), .trainer_dir(t3_dir),
    .walk_frame(t3_wf), .start_battle(t3_sb), .battle_idx(t3_idx),
    .new_room(t3_nr), .defeated(t3_def)
  );

  // Pulse monitors, sampled on the falling edge.
  always @(negedge Clk) begin
    if (start_battle) sb_cnt <= sb_cnt + 1;
    if (new_room) begin
      nr_cnt <= nr_cnt + 1;
      nr_x   <= trainer_x;
      nr_y   <= trainer_y;
      nr_def <= defeated;
    end
  end

  typedef struct {
    logic [7:0] key;
    int         n;
    int         ex;
    int         ey;
    int         edir;
    bit         cw;
    int         ewf;
  } row_t;

  row_t rows[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_tick(input logic [7:0] key);
    keycode   = key;
    frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic run_row(input int i);
    for (int k = 0; k < rows[i].n; k++) do_tick(rows[i].key);
    check($sformatf("row%0d_x", i), trainer_x, rows[i].ex);
    check($sformatf("row%0d_y", i), trainer_y, rows[i].ey);
    check($sformatf("row%0d_dir", i), trainer_dir, rows[i].edir);
    if (rows[i].cw) check($sformatf("row%0d_wf", i), walk_frame, rows[i].ewf);
  endtask

  task automatic pulse_done();
    battle_done = 1'b1;
    @(posedge Clk); #1;
    battle_done = 1'b0;
  endtask

  initial begin
    int base;
    rows[0]  = '{8'h1A, 10,  387, 326, 0, 1'b1, 2};
    rows[1]  = '{8'h07, 1,   387, 326, 3, 1'b0, 0};
    rows[2]  = '{8'h07, 2,   389, 326, 3, 1'b1, 0};
    rows[3]  = '{8'h1A, 1,   389, 326, 0, 1'b0, 0};
    rows[4]  = '{8'h1A, 97,  389, 229, 0, 1'b1, 1};
    rows[5]  = '{8'h00, 1,   389, 229, 0, 1'b1, 0};
    rows[6]  = '{8'h07, 1,   389, 228, 3, 1'b0, 0};
    rows[7]  = '{8'h07, 1,   390, 228, 3, 1'b0, 0};
    rows[8]  = '{8'h1A, 1,   390, 228, 0, 1'b0, 0};
    rows[9]  = '{8'h00, 1,   390, 228, 0, 1'b1, 0};
    rows[10] = '{8'h1A, 103, 390, 125, 0, 1'b1, 3};
    rows[11] = '{8'h1A, 2,   390, 125, 0, 1'b0, 0};

    Reset = 1'b1; frame_clk = 1'b0; is_roam = 1'b1; is_start = 1'b0;
    battle_done = 1'b0; keycode = 8'h00; npc_active = '0;
    npc_x = '0; npc_y = '0;
    repeat (3) @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;

    check("rst_x", trainer_x, 387);
    check("rst_y", trainer_y, 336);
    check("rst_dir", trainer_dir, 0);
    check("rst_wf", walk_frame, 0);
    check("rst_def", defeated, 0);
    check("rst_idx", battle_idx, 0);
    check("rst_sb", start_battle, 0);
    check("rst_nr", new_room, 0);

    // Movement table, first leg up to the NPC row.
    for (int i = 0; i <= 5; i++) begin
      run_row(i);
      if (i == 0) begin
        check("div3_y", t3_y, 333);
        check("div3_wf", t3_wf, 3);
        check("div3_x", t3_x, 387);
        check("div3_dir", t3_dir, 0);
        check("div3_quiet", {t3_sb, t3_nr, t3_idx, t3_def}, 0);
      end
    end

    // Ticks while the roam screen is inactive do nothing.
    is_roam = 1'b0;
    do_tick(8'h1A);
    check("noroam_y", trainer_y, 229);
    is_roam = 1'b1;

    // ENTER picks lowest-index NPC; held ENTER never retriggers.
    npc_x[0] = 10'd389; npc_y[0] = 10'd212;
    npc_x[2] = 10'd390; npc_y[2] = 10'd212;
    npc_active = 5'b00101;
    base = sb_cnt;
    keycode = 8'h28;
    @(posedge Clk); #1;
    check("enter0_sb", start_battle, 1);
    check("enter0_idx", battle_idx, 0);
    @(posedge Clk); #1;
    check("enter0_sb_len", start_battle, 0);
    repeat (50) @(posedge Clk); #1;
    check("enter0_hold", sb_cnt, base + 1);

    // Position frozen in battle.
    for (int k = 0; k < 3; k++) do_tick(8'h1A);
    check("battle_x", trainer_x, 389);
    check("battle_y", trainer_y, 229);

    // Finish battle while ENTER is held; no retrigger afterwards.
    keycode = 8'h28;
    @(posedge Clk); #1;
    base = sb_cnt;
    pulse_done();
    check("def_0", defeated, 5'b00001);
    repeat (50) @(posedge Clk); #1;
    check("held_after_done", sb_cnt, base);

    // A defeated NPC still blocks movement.
    npc_active = 5'b00001;
    do_tick(8'h1A);
    check("step_228", trainer_y, 228);
    do_tick(8'h1A);
    check("blocked_228", trainer_y, 228);
    npc_active = 5'b00101;

    keycode = 8'h00;
    @(posedge Clk); #1;
    keycode = 8'h28;
    @(posedge Clk); #1;
    check("enter2_sb", start_battle, 1);
    check("enter2_idx", battle_idx, 2);
    @(posedge Clk); #1;
    pulse_done();
    check("def_02", defeated, 5'b00101);

    // Exit leg: NPC1 active and undefeated keeps the door shut.
    npc_x[0] = 10'd300; npc_y[0] = 10'd300;
    npc_x[2] = 10'd320; npc_y[2] = 10'd300;
    npc_x[1] = 10'd340; npc_y[1] = 10'd300;
    npc_active = 5'b00111;
    for (int i = 6; i <= 11; i++) run_row(i);
    check("no_exit", nr_cnt, 0);

    npc_x[1] = 10'd390; npc_y[1] = 10'd109;
    keycode = 8'h28;
    @(posedge Clk); #1;
    check("enter1_sb", start_battle, 1);
    check("enter1_idx", battle_idx, 1);
    keycode = 8'h00;
    @(posedge Clk); #1;
    pulse_done();
    check("def_012", defeated, 5'b00111);

    do_tick(8'h1A);
    check("exit_cnt", nr_cnt, 1);
    check("exit_nr_x", nr_x, 387);
    check("exit_nr_y", nr_y, 336);
    check("exit_nr_def", nr_def, 0);
    check("exit_x", trainer_x, 387);
    check("exit_y", trainer_y, 336);
    check("exit_dir", trainer_dir, 0);
    check("exit_def", defeated, 0);

    // Soft reset wins over a simultaneous battle_done.
    npc_x[0] = 10'd387; npc_y[0] = 10'd320;
    npc_active = 5'b00001;
    keycode = 8'h28;
    @(posedge Clk); #1;
    check("enter3_sb", start_battle, 1);
    keycode = 8'h00;
    is_start = 1'b1;
    battle_done = 1'b1;
    @(posedge Clk); #1;
    is_start = 1'b0;
    battle_done = 1'b0;
    check("soft_def", defeated, 0);
    check("soft_x", trainer_x, 387);
    check("soft_y", trainer_y, 336);
    check("soft_idx", battle_idx, 0);
    check("soft_sb", start_battle, 0);
    keycode = 8'h28;
    @(posedge Clk); #1;
    check("soft_roam_sb", start_battle, 1);
    check("soft_roam_idx", battle_idx, 0);
    keycode = 8'h00;
    repeat (4) @(posedge Clk); #1;
    check("nr_total", nr_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
